// File: rtl/button_pkg.sv
// Shared types and default timing constants for the push-button conditioner.
package button_pkg;

  localparam int DEBOUNCE_DEFAULT = 1_000_000;
  localparam int HOLD_DEFAULT     = 100_000_000;

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    WAIT_HIGH = 2'd1,
    HIGH      = 2'd2,
    WAIT_LOW  = 2'd3
  } state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing an asynchronous level into the clk domain.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Debounces a raw button and emits registered level, press, release and
// one-shot hold pulses from a single shared debounce/hold counter.
module button_conditioner
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int HOLD_CYCLES     = HOLD_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_hold
);

  localparam int          MAX_CYCLES = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
  localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? 32'($clog2(MAX_CYCLES)) : 32'd1;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 1) begin : g_bad_cfg
    $error("button_conditioner: DEBOUNCE_CYCLES and HOLD_CYCLES must both be >= 1");
  end

  logic btn_sync;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_in),
    .q     (btn_sync)
  );

  state_e           state, next_state;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             armed, armed_d;
  logic             level_d, press_d, release_d, hold_d;

  // State, counter, hold-arm flag and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= LOW;
      cnt         <= '0;
      armed       <= 1'b0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      btn_hold    <= 1'b0;
    end else begin
      state       <= next_state;
      cnt         <= cnt_d;
      armed       <= armed_d;
      btn_level   <= level_d;
      btn_press   <= press_d;
      btn_release <= release_d;
      btn_hold    <= hold_d;
    end
  end

  // Next-state logic; the counter times debounce in WAIT_* and hold in HIGH
  always_comb begin
    next_state = state;
    cnt_d      = cnt;
    armed_d    = armed;
    press_d    = 1'b0;
    release_d  = 1'b0;
    hold_d     = 1'b0;

    unique case (state)
      LOW: begin
        if (btn_sync) begin
          next_state = WAIT_HIGH;
          cnt_d      = '0;
        end
      end
      WAIT_HIGH: begin
        if (!btn_sync) begin
          next_state = LOW;
          cnt_d      = '0;
        end else if (cnt == DEB_LAST) begin
          next_state = HIGH;
          cnt_d      = '0;
          press_d    = 1'b1;
          armed_d    = 1'b1;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      HIGH: begin
        if (!btn_sync) begin
          next_state = WAIT_LOW;
          cnt_d      = '0;
        end else begin
          if (cnt != HOLD_LAST) cnt_d = cnt + CNT_W'(1);
          // Hold fires only from HIGH, so it can never coincide with press
          if (armed && cnt_d == HOLD_LAST) begin
            hold_d  = 1'b1;
            armed_d = 1'b0;
          end
        end
      end
      WAIT_LOW: begin
        if (btn_sync) begin
          next_state = HIGH;
          cnt_d      = '0;
        end else if (cnt == DEB_LAST) begin
          next_state = LOW;
          cnt_d      = '0;
          release_d  = 1'b1;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      default: begin
        next_state = LOW;
        cnt_d      = '0;
      end
    endcase

    level_d = (next_state == HIGH) || (next_state == WAIT_LOW);
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Randomized self-checking bench for button_conditioner with a run-length reference model.
module tb_button_conditioner;

  localparam int D = 4;
  localparam int H = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_in = 1'b0;
  logic btn_level, btn_press, btn_release, btn_hold;

  button_conditioner #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H)) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_in      (btn_in),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_hold    (btn_hold)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference: the debounced level flips once D+1 consecutive synchronized
  // samples disagree with it; hold fires after H-1 further high samples.
  bit m_s1, m_s2, m_level, m_press, m_rel, m_hold, m_armed;
  int m_run, m_hc;

  function automatic void model_step(input bit b, input bit r);
    bit samp;
    m_press = 0; m_rel = 0; m_hold = 0;
    if (r) begin
      m_s1 = 0; m_s2 = 0; m_level = 0; m_run = 0; m_armed = 0; m_hc = -1;
      return;
    end
    samp = m_s2;
    m_s2 = m_s1;
    m_s1 = b;
    if (samp != m_level) begin
      m_run++;
      if (m_run == D + 1) begin
        m_level = samp;
        m_run   = 0;
        if (samp) begin
          m_press = 1; m_armed = 1; m_hc = 0;
        end else begin
          m_rel = 1;
        end
      end
    end else begin
      m_run = 0;
    end
    if (m_level && !m_press) begin
      if (!samp) m_hc = -1;
      else begin
        m_hc = (m_hc + 1 > H - 1) ? H - 1 : m_hc + 1;
        if (m_armed && m_hc == H - 1) begin
          m_hold = 1; m_armed = 0;
        end
      end
    end
  endfunction

  task automatic tick(input logic b, input logic r);
    btn_in = b;
    reset  = r;
    @(posedge clk);
    cyc++;
    model_step(b, r);
    #1;
  endtask

  task automatic test_reset();
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b1);
    n_checks++;
    if ({btn_level, btn_press, btn_release, btn_hold} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 0000", {btn_level, btn_press, btn_release, btn_hold});
    end
  endtask

  task automatic test_clean_press();
    int c0, press_at, n_press;
    press_at = -1; n_press = 0;
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b0);
    c0 = cyc + 1;
    for (int i = 0; i < 20; i++) begin
      tick(1'b1, 1'b0);
      n_checks++;
      if ({btn_level, btn_press, btn_release, btn_hold} !== {m_level, m_press, m_rel, m_hold}) begin
        n_fail++;
        $display("FAIL clean_press cyc %0d: got %b expected %b", cyc,
                 {btn_level, btn_press, btn_release, btn_hold}, {m_level, m_press, m_rel, m_hold});
      end
      if (btn_press === 1'b1) begin
        n_press++;
        if (press_at < 0) press_at = cyc;
        n_checks++;
        if (btn_level !== 1'b1) begin
          n_fail++;
          $display("FAIL clean_press_level: got %b expected 1", btn_level);
        end
      end
    end
    n_checks++;
    if (press_at != c0 + 6 || n_press != 1) begin
      n_fail++;
      $display("FAIL clean_press_latency: got edge %0d count %0d expected edge %0d count 1",
               press_at - c0, n_press, 6);
    end
    for (int i = 0; i < 15; i++) tick(1'b0, 1'b0);
  endtask

  task automatic test_bounce_reject();
    int n_press, n_level;
    n_press = 0; n_level = 0;
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 3; i++) begin
        tick(1'b1, 1'b0);
        if (btn_press === 1'b1) n_press++;
        if (btn_level !== 1'b0) n_level++;
      end
      for (int i = 0; i < int'($urandom_range(1, 4)); i++) begin
        tick(1'b0, 1'b0);
        if (btn_press === 1'b1) n_press++;
        if (btn_level !== 1'b0) n_level++;
      end
    end
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b0);
    n_checks++;
    if (n_press != 0 || n_level != 0) begin
      n_fail++;
      $display("FAIL bounce_reject: got %0d presses %0d level-high cycles expected 0 and 0", n_press, n_level);
    end
  endtask

  task automatic test_hold();
    int c0, press_at, hold_at, rel_at, n_press, n_hold, n_rel, f;
    press_at = -1; hold_at = -1; rel_at = -1; n_press = 0; n_hold = 0; n_rel = 0;
    c0 = cyc + 1;
    for (int i = 0; i < 40; i++) begin
      tick(1'b1, 1'b0);
      n_checks++;
      if ({btn_level, btn_press, btn_release, btn_hold} !== {m_level, m_press, m_rel, m_hold}) begin
        n_fail++;
        $display("FAIL hold_trace cyc %0d: got %b expected %b", cyc,
                 {btn_level, btn_press, btn_release, btn_hold}, {m_level, m_press, m_rel, m_hold});
      end
      if (btn_press === 1'b1) begin n_press++; press_at = cyc; end
      if (btn_hold === 1'b1) begin n_hold++; hold_at = cyc; end
    end
    f = cyc + 1;
    for (int i = 0; i < 15; i++) begin
      tick(1'b0, 1'b0);
      if (btn_release === 1'b1) begin n_rel++; rel_at = cyc; end
      if (btn_hold === 1'b1) n_hold++;
    end
    n_checks++;
    if (n_press != 1 || press_at != c0 + 6) begin
      n_fail++;
      $display("FAIL hold_press: got count %0d at %0d expected count 1 at 6", n_press, press_at - c0);
    end
    n_checks++;
    if (n_hold != 1 || hold_at - press_at != 9) begin
      n_fail++;
      $display("FAIL hold_pulse: got count %0d offset %0d expected count 1 offset 9", n_hold, hold_at - press_at);
    end
    n_checks++;
    if (n_rel != 1 || rel_at - f != 6) begin
      n_fail++;
      $display("FAIL hold_release: got count %0d offset %0d expected count 1 offset 6", n_rel, rel_at - f);
    end
  endtask

  task automatic test_release_glitch();
    int n_press, n_rel, n_low;
    n_press = 0; n_rel = 0; n_low = 0;
    for (int i = 0; i < 15; i++) tick(1'b1, 1'b0);
    for (int i = 0; i < 17; i++) begin
      tick((i < 2) ? 1'b0 : 1'b1, 1'b0);
      if (btn_press === 1'b1) n_press++;
      if (btn_release === 1'b1) n_rel++;
      if (btn_level !== 1'b1) n_low++;
      n_checks++;
      if ({btn_level, btn_press, btn_release, btn_hold} !== {m_level, m_press, m_rel, m_hold}) begin
        n_fail++;
        $display("FAIL glitch_trace cyc %0d: got %b expected %b", cyc,
                 {btn_level, btn_press, btn_release, btn_hold}, {m_level, m_press, m_rel, m_hold});
      end
    end
    n_checks++;
    if (n_press != 0 || n_rel != 0 || n_low != 0) begin
      n_fail++;
      $display("FAIL release_glitch: got press %0d release %0d low %0d expected 0 0 0", n_press, n_rel, n_low);
    end
    for (int i = 0; i < 15; i++) tick(1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    int rd, press_at, n_rel;
    press_at = -1; n_rel = 0;
    for (int i = 0; i < 12; i++) tick(1'b1, 1'b0);
    n_checks++;
    if (btn_level !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_pre: got level %b expected 1", btn_level);
    end
    tick(1'b1, 1'b1);
    n_checks++;
    if ({btn_level, btn_press, btn_release, btn_hold} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_mid_clear: got %b expected 0000", {btn_level, btn_press, btn_release, btn_hold});
    end
    rd = cyc + 1;
    for (int i = 0; i < 12; i++) begin
      tick(1'b1, 1'b0);
      if (btn_press === 1'b1 && press_at < 0) press_at = cyc;
      if (btn_release === 1'b1) n_rel++;
    end
    n_checks++;
    if (press_at - rd != 6 || n_rel != 0) begin
      n_fail++;
      $display("FAIL reset_mid_repress: got offset %0d releases %0d expected offset 6 releases 0", press_at - rd, n_rel);
    end
    for (int i = 0; i < 15; i++) tick(1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic b;
    int run;
    b = 1'b0; run = 0;
    for (int i = 0; i < 1500; i++) begin
      if (run == 0) begin
        b   = ~b;
        run = ($urandom_range(0, 3) == 0) ? int'($urandom_range(8, 25)) : int'($urandom_range(1, 7));
      end
      run--;
      tick(b, ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
      n_checks++;
      if ({btn_level, btn_press, btn_release, btn_hold} !== {m_level, m_press, m_rel, m_hold}) begin
        n_fail++;
        $display("FAIL random_trace cyc %0d: got %b expected %b", cyc,
                 {btn_level, btn_press, btn_release, btn_hold}, {m_level, m_press, m_rel, m_hold});
      end
      n_checks++;
      if ((32'(btn_press) + 32'(btn_release) + 32'(btn_hold)) > 1) begin
        n_fail++;
        $display("FAIL random_exclusive cyc %0d: got press/release/hold %b%b%b expected at most one",
                 cyc, btn_press, btn_release, btn_hold);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce_reject();
    test_hold();
    test_release_glitch();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 The module SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000, the required stable-input time in clk cycles (10 ms at 100 MHz).
REQ-002 The module SHALL have parameter HOLD_CYCLES, default 100_000_000, the debounced-high time in clk cycles before a hold event (1 s at 100 MHz).
REQ-003 Port clk SHALL be input, 1 bit: the single system clock; all logic is in this domain.
REQ-004 Port reset SHALL be input, 1 bit: synchronous, active-high reset.
REQ-005 Port btn_in SHALL be input, 1 bit: raw asynchronous push-button or switch level.
REQ-006 Port btn_level SHALL be output, 1 bit: debounced button level.
REQ-007 Port btn_press SHALL be output, 1 bit: one-cycle pulse on a debounced rising edge.
REQ-008 Port btn_release SHALL be output, 1 bit: one-cycle pulse on a debounced falling edge.
REQ-009 Port btn_hold SHALL be output, 1 bit: one-cycle pulse once per press, after HOLD_CYCLES of debounced high.

Function
REQ-010 btn_in SHALL pass through a two-flop synchronizer; btn_sync is the second flop output, and no other logic samples btn_in.
REQ-011 The FSM SHALL have exactly four states: LOW, WAIT_HIGH, HIGH, WAIT_LOW.
REQ-012 LOW: btn_sync=1 SHALL move to WAIT_HIGH with the counter cleared to 0.
REQ-013 WAIT_HIGH: btn_sync=0 (bounce) SHALL return to LOW with no pulse; btn_sync=1 with counter=DEBOUNCE_CYCLES-1 SHALL move to HIGH; otherwise the counter SHALL increment.
REQ-014 HIGH: btn_sync=0 SHALL move to WAIT_LOW with the counter cleared; otherwise the hold counter SHALL increment and saturate at HOLD_CYCLES-1.
REQ-015 WAIT_LOW: btn_sync=1 SHALL return to HIGH without a press pulse and without re-arming hold; btn_sync=0 with counter=DEBOUNCE_CYCLES-1 SHALL move to LOW; otherwise the counter SHALL increment.
REQ-016 All outputs SHALL be registered.
REQ-017 btn_press SHALL be 1 for exactly the cycle in which the state first reads HIGH after WAIT_HIGH.
REQ-018 With btn_in first sampled high at edge k and held, btn_press SHALL be high in the cycle following edge k+DEBOUNCE_CYCLES+2.
REQ-019 btn_release SHALL be 1 for exactly the cycle in which the state first reads LOW after WAIT_LOW, with the same symmetric latency as REQ-018.
REQ-020 btn_level SHALL be 1 in states HIGH and WAIT_LOW, and 0 in states LOW and WAIT_HIGH.
REQ-021 btn_hold SHALL pulse exactly one cycle when the hold counter reaches HOLD_CYCLES-1 in HIGH; it SHALL not repeat while held, and SHALL be re-armed only by a fresh btn_press.
REQ-022 A single shared counter SHALL be used, with width $clog2 of max(DEBOUNCE_CYCLES, HOLD_CYCLES); it SHALL never wrap.
REQ-023 btn_press, btn_release and btn_hold SHALL never be asserted in the same cycle.
REQ-024 DEBOUNCE_CYCLES < 1 or HOLD_CYCLES < 1 SHALL be rejected at elaboration.

Reset
REQ-025 Reset SHALL put the FSM in LOW, clear both synchronizer flops, clear the counter and the hold-armed flag, and drive all outputs to 0 on the next edge.
REQ-026 Reset SHALL take priority over every other event, including mid-debounce and mid-hold.
REQ-027 No release pulse SHALL be generated by reset.
REQ-028 A button still held when reset is removed SHALL be re-debounced and SHALL produce btn_press per REQ-018.

Structure
REQ-029 Package button_pkg SHALL hold the FSM state enum typedef and the default cycle constants DEBOUNCE_DEFAULT and HOLD_DEFAULT.
REQ-030 The synchronizer SHALL be a separate sub-module, sync_2ff (clk, reset, d, q).
REQ-031 All other logic SHALL be flat in button_conditioner.

Verification (DEBOUNCE_CYCLES=4, HOLD_CYCLES=10)
REQ-032 Clean press: btn_in 0->1 at edge 0, held -> btn_press one cycle after edge 6; btn_level=1 from the same cycle.
REQ-033 Bounce reject: btn_in high for 3 cycles, then low, repeated 5 times -> no btn_press, btn_level stays 0.
REQ-034 Hold: btn_in held 40 cycles -> exactly one btn_press and exactly one btn_hold, 9 cycles after btn_press; release -> one btn_release 6 cycles after the falling input.
REQ-035 Release glitch: while HIGH, btn_in low for 2 cycles then high -> no btn_release, no second btn_press, btn_level stays 1.
REQ-036 Reset mid-operation: reset for 1 cycle during HIGH with btn_in still high -> all outputs 0 next cycle, then btn_press again 6 cycles after reset deassertion.
